write_record_table: RTL and testbench

- Holds the in-flight instruction records that the downstream write-hazard checkers compare against.
- Allocates a record when an instruction issues.
- Accumulates per-element completion bits into each record's element mask as lanes finish element groups.
- Frees the record on retire.
- Presents every record as registered outputs, one slot per downstream checker instance.

---
 rtl/write_record_table.sv | 194 +++++++++++++++++++
 tb/tb_write_record_table.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_record_table.sv
`default_nettype none
// ============================================================================
// Module   : write_record_table
// Purpose  : Table of in-flight instruction records used by the downstream
//            write-hazard checkers. A record is allocated on issue, its
//            element mask accumulates completion bits, and it is freed on
//            retire. Every record is presented as registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module write_record_table #(
    parameter  int DEPTH  = 4,
    parameter  int MASK_W = 4096,
    parameter  int UPD_W  = 32,
    localparam int WORDS  = MASK_W / UPD_W,
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic                      issue_bits_vd_valid,
    input  logic [4:0]                issue_bits_vd,
    input  logic                      issue_bits_vs1_valid,
    input  logic [4:0]                issue_bits_vs1,
    input  logic [4:0]                issue_bits_vs2,
    input  logic [2:0]                issue_bits_instIndex,
    input  logic                      issue_bits_gather,
    input  logic                      issue_bits_gather16,
    input  logic                      issue_bits_onlyRead,

    input  logic                      update_valid,
    input  logic [2:0]                update_instIndex,
    input  logic [WIDX_W-1:0]         update_wordIndex,
    input  logic [UPD_W-1:0]          update_bits,

    input  logic                      retire_valid,
    input  logic [2:0]                retire_instIndex,

    output logic [DEPTH-1:0]          record_valid,
    output logic [DEPTH-1:0]          record_bits_vd_valid,
    output logic [DEPTH*5-1:0]        record_bits_vd,
    output logic [DEPTH-1:0]          record_bits_vs1_valid,
    output logic [DEPTH*5-1:0]        record_bits_vs1,
    output logic [DEPTH*5-1:0]        record_bits_vs2,
    output logic [DEPTH*3-1:0]        record_bits_instIndex,
    output logic [DEPTH-1:0]          record_bits_gather,
    output logic [DEPTH-1:0]          record_bits_gather16,
    output logic [DEPTH-1:0]          record_bits_onlyRead,
    output logic [DEPTH*MASK_W-1:0]   record_bits_elementMask,
    output logic [DEPTH-1:0]          record_complete,
    output logic [CNT_W-1:0]          occupancy,
    output logic                      error
);

    // Per-slot state
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][MASK_W-1:0] mask_q, mask_d;
    logic [DEPTH-1:0]             complete_q, complete_d;
    logic [CNT_W-1:0]             occ_q, occ_d;
    logic                         error_q, error_d;

    // Issue fields, loaded only when a slot is allocated
    logic [DEPTH-1:0]             vd_valid_q;
    logic [DEPTH-1:0][4:0]        vd_q;
    logic [DEPTH-1:0]             vs1_valid_q;
    logic [DEPTH-1:0][4:0]        vs1_q;
    logic [DEPTH-1:0][4:0]        vs2_q;
    logic [DEPTH-1:0][2:0]        inst_q;
    logic [DEPTH-1:0]             gather_q;
    logic [DEPTH-1:0]             gather16_q;
    logic [DEPTH-1:0]             only_read_q;

    // Decode of this cycle's events
    logic [DEPTH-1:0]             alloc_oh;
    logic                         alloc_found;
    logic [DEPTH-1:0]             upd_hit;
    logic [DEPTH-1:0]             ret_hit;
    logic [DEPTH-1:0]             dup_hit;
    logic                         issue_fire;

    // Ready depends only on registered state, never on this cycle's retire
    assign issue_ready = ~(&valid_q);
    assign issue_fire  = issue_valid & issue_ready;

    // Lowest free slot and per-slot index matches against pre-edge state
    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        upd_hit     = '0;
        ret_hit     = '0;
        dup_hit     = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (!valid_q[s] && !alloc_found) begin
                alloc_oh[s] = 1'b1;
                alloc_found = 1'b1;
            end
            upd_hit[s] = update_valid & valid_q[s] & (inst_q[s] == update_instIndex);
            ret_hit[s] = retire_valid & valid_q[s] & (inst_q[s] == retire_instIndex);
            dup_hit[s] = valid_q[s] & (inst_q[s] == issue_bits_instIndex);
        end
    end

    // Next valid/mask state; allocation targets a free slot so it cannot
    // collide with a hit, and retire overrides an update to the same slot
    always_comb begin
        valid_d    = valid_q;
        mask_d     = mask_q;
        complete_d = '0;
        occ_d      = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (issue_fire && alloc_oh[s]) begin
                valid_d[s] = 1'b1;
                mask_d[s]  = '0;
            end else if (ret_hit[s]) begin
                valid_d[s] = 1'b0;
                mask_d[s]  = '0;
            end else if (upd_hit[s]) begin
                mask_d[s][int'(update_wordIndex) * UPD_W +: UPD_W] =
                    mask_q[s][int'(update_wordIndex) * UPD_W +: UPD_W] | update_bits;
            end
            complete_d[s] = valid_d[s] & (&mask_d[s]);
            occ_d         = occ_d + {{(CNT_W-1){1'b0}}, valid_d[s]};
        end
        error_d = error_q
                | (update_valid & ~(|upd_hit))
                | (retire_valid & ~(|ret_hit))
                | (issue_fire & (|dup_hit));
    end

    // Valid, mask, completion, occupancy and sticky error registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            mask_q     <= '0;
            complete_q <= '0;
            occ_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            mask_q     <= mask_d;
            complete_q <= complete_d;
            occ_q      <= occ_d;
            error_q    <= error_d;
        end
    end

    // Issue fields captured into the allocated slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vd_valid_q  <= '0;
            vd_q        <= '0;
            vs1_valid_q <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            inst_q      <= '0;
            gather_q    <= '0;
            gather16_q  <= '0;
            only_read_q <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (issue_fire && alloc_oh[s]) begin
                    vd_valid_q[s]  <= issue_bits_vd_valid;
                    vd_q[s]        <= issue_bits_vd;
                    vs1_valid_q[s] <= issue_bits_vs1_valid;
                    vs1_q[s]       <= issue_bits_vs1;
                    vs2_q[s]       <= issue_bits_vs2;
                    inst_q[s]      <= issue_bits_instIndex;
                    gather_q[s]    <= issue_bits_gather;
                    gather16_q[s]  <= issue_bits_gather16;
                    only_read_q[s] <= issue_bits_onlyRead;
                end
            end
        end
    end

    assign record_valid            = valid_q;
    assign record_bits_vd_valid    = vd_valid_q;
    assign record_bits_vd          = vd_q;
    assign record_bits_vs1_valid   = vs1_valid_q;
    assign record_bits_vs1         = vs1_q;
    assign record_bits_vs2         = vs2_q;
    assign record_bits_instIndex   = inst_q;
    assign record_bits_gather      = gather_q;
    assign record_bits_gather16    = gather16_q;
    assign record_bits_onlyRead    = only_read_q;
    assign record_bits_elementMask = mask_q;
    assign record_complete         = complete_q;
    assign occupancy               = occ_q;
    assign error                   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_write_record_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_record_table
// Purpose  : Directed self-checking bench for write_record_table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_record_table;

    localparam int DEPTH  = 4;
    localparam int MASK_W = 4096;
    localparam int UPD_W  = 32;
    localparam int WORDS  = MASK_W / UPD_W;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    issue_valid;
    logic                    issue_ready;
    logic                    issue_bits_vd_valid;
    logic [4:0]              issue_bits_vd;
    logic                    issue_bits_vs1_valid;
    logic [4:0]              issue_bits_vs1;
    logic [4:0]              issue_bits_vs2;
    logic [2:0]              issue_bits_instIndex;
    logic                    issue_bits_gather;
    logic                    issue_bits_gather16;
    logic                    issue_bits_onlyRead;
    logic                    update_valid;
    logic [2:0]              update_instIndex;
    logic [6:0]              update_wordIndex;
    logic [UPD_W-1:0]        update_bits;
    logic                    retire_valid;
    logic [2:0]              retire_instIndex;
    logic [DEPTH-1:0]        record_valid;
    logic [DEPTH-1:0]        record_bits_vd_valid;
    logic [DEPTH*5-1:0]      record_bits_vd;
    logic [DEPTH-1:0]        record_bits_vs1_valid;
    logic [DEPTH*5-1:0]      record_bits_vs1;
    logic [DEPTH*5-1:0]      record_bits_vs2;
    logic [DEPTH*3-1:0]      record_bits_instIndex;
    logic [DEPTH-1:0]        record_bits_gather;
    logic [DEPTH-1:0]        record_bits_gather16;
    logic [DEPTH-1:0]        record_bits_onlyRead;
    logic [DEPTH*MASK_W-1:0] record_bits_elementMask;
    logic [DEPTH-1:0]        record_complete;
    logic [2:0]              occupancy;
    logic                    error;

    int n_checks = 0;
    int n_fails  = 0;

    write_record_table #(.DEPTH(DEPTH), .MASK_W(MASK_W), .UPD_W(UPD_W)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .issue_valid             (issue_valid),
        .issue_ready             (issue_ready),
        .issue_bits_vd_valid     (issue_bits_vd_valid),
        .issue_bits_vd           (issue_bits_vd),
        .issue_bits_vs1_valid    (issue_bits_vs1_valid),
        .issue_bits_vs1          (issue_bits_vs1),
        .issue_bits_vs2          (issue_bits_vs2),
        .issue_bits_instIndex    (issue_bits_instIndex),
        .issue_bits_gather       (issue_bits_gather),
        .issue_bits_gather16     (issue_bits_gather16),
        .issue_bits_onlyRead     (issue_bits_onlyRead),
        .update_valid            (update_valid),
        .update_instIndex        (update_instIndex),
        .update_wordIndex        (update_wordIndex),
        .update_bits             (update_bits),
        .retire_valid            (retire_valid),
        .retire_instIndex        (retire_instIndex),
        .record_valid            (record_valid),
        .record_bits_vd_valid    (record_bits_vd_valid),
        .record_bits_vd          (record_bits_vd),
        .record_bits_vs1_valid   (record_bits_vs1_valid),
        .record_bits_vs1         (record_bits_vs1),
        .record_bits_vs2         (record_bits_vs2),
        .record_bits_instIndex   (record_bits_instIndex),
        .record_bits_gather      (record_bits_gather),
        .record_bits_gather16    (record_bits_gather16),
        .record_bits_onlyRead    (record_bits_onlyRead),
        .record_bits_elementMask (record_bits_elementMask),
        .record_complete         (record_complete),
        .occupancy               (occupancy),
        .error                   (error)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int s, input int w);
        return record_bits_elementMask[s*MASK_W + w*UPD_W +: UPD_W];
    endfunction

    task automatic clear_inputs();
        issue_valid          = 1'b0;
        issue_bits_vd_valid  = 1'b0;
        issue_bits_vd        = '0;
        issue_bits_vs1_valid = 1'b0;
        issue_bits_vs1       = '0;
        issue_bits_vs2       = '0;
        issue_bits_instIndex = '0;
        issue_bits_gather    = 1'b0;
        issue_bits_gather16  = 1'b0;
        issue_bits_onlyRead  = 1'b0;
        update_valid         = 1'b0;
        update_instIndex     = '0;
        update_wordIndex     = '0;
        update_bits          = '0;
        retire_valid         = 1'b0;
        retire_instIndex     = '0;
    endtask

    // Advance one clock edge, settle, then drop all request strobes
    task automatic step();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic set_issue(input logic [2:0] idx, input logic [4:0] vd);
        issue_valid          = 1'b1;
        issue_bits_instIndex = idx;
        issue_bits_vd        = vd;
        issue_bits_vd_valid  = 1'b1;
    endtask

    task automatic set_update(input logic [2:0] idx, input logic [6:0] w, input logic [31:0] b);
        update_valid     = 1'b1;
        update_instIndex = idx;
        update_wordIndex = w;
        update_bits      = b;
    endtask

    task automatic set_retire(input logic [2:0] idx);
        retire_valid     = 1'b1;
        retire_instIndex = idx;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #3;
        chk("rst_valid", 64'(record_valid), 64'h0);
        chk("rst_occ",   64'(occupancy), 64'h0);
        chk("rst_err",   64'(error), 64'h0);
        chk("rst_ready", 64'(issue_ready), 64'h1);
        @(negedge clock);
        reset = 1'b1;

        // 1: single issue
        set_issue(3'd0, 5'd8);
        issue_bits_vs1_valid = 1'b1;
        issue_bits_vs1       = 5'd3;
        issue_bits_vs2       = 5'd4;
        issue_bits_gather    = 1'b1;
        step();
        chk("t1_valid",   64'(record_valid), 64'h1);
        chk("t1_vd",      64'(record_bits_vd[4:0]), 64'd8);
        chk("t1_vdv",     64'(record_bits_vd_valid), 64'h1);
        chk("t1_vs1",     64'(record_bits_vs1[4:0]), 64'd3);
        chk("t1_vs2",     64'(record_bits_vs2[4:0]), 64'd4);
        chk("t1_gather",  64'(record_bits_gather), 64'h1);
        chk("t1_mask",    64'(mword(0, 0)), 64'h0);
        chk("t1_occ",     64'(occupancy), 64'd1);
        chk("t1_ready",   64'(issue_ready), 64'h1);

        // 2: fill the table
        for (int i = 1; i < 4; i++) begin
            set_issue(3'(i), 5'(8 + i));
            step();
        end
        chk("t2_valid", 64'(record_valid), 64'hF);
        chk("t2_ready", 64'(issue_ready), 64'h0);
        chk("t2_occ",   64'(occupancy), 64'd4);
        chk("t2_inst",  64'(record_bits_instIndex), 64'h688);
        set_issue(3'd5, 5'd20);
        step();
        chk("t2_full_valid", 64'(record_valid), 64'hF);
        chk("t2_full_inst",  64'(record_bits_instIndex), 64'h688);
        chk("t2_full_occ",   64'(occupancy), 64'd4);
        chk("t2_full_err",   64'(error), 64'h0);

        // 3: accumulate completion bits on slot 0
        set_update(3'd0, 7'd0, 32'h0000FFFF);
        step();
        chk("t3_w0_lo", 64'(mword(0, 0)), 64'h0000FFFF);
        set_update(3'd0, 7'd0, 32'hFFFF0000);
        step();
        chk("t3_w0_all", 64'(mword(0, 0)), 64'hFFFFFFFF);
        chk("t3_cmp0",   64'(record_complete), 64'h0);
        for (int w = 0; w < WORDS; w++) begin
            set_update(3'd0, 7'(w), 32'hFFFFFFFF);
            step();
            if (w == WORDS - 2)
                chk("t3_cmp_early", 64'(record_complete), 64'h0);
        end
        chk("t3_cmp",    64'(record_complete), 64'h1);
        chk("t3_w127",   64'(mword(0, WORDS - 1)), 64'hFFFFFFFF);
        chk("t3_s1_w0",  64'(mword(1, 0)), 64'h0);
        chk("t3_err",    64'(error), 64'h0);

        // 4: retire and issue together while full
        set_retire(3'd1);
        set_issue(3'd4, 5'd20);
        step();
        chk("t4_valid", 64'(record_valid), 64'hD);
        chk("t4_occ",   64'(occupancy), 64'd3);
        chk("t4_ready", 64'(issue_ready), 64'h1);
        set_issue(3'd4, 5'd20);
        step();
        chk("t4_valid2", 64'(record_valid), 64'hF);
        chk("t4_inst1",  64'(record_bits_instIndex[5:3]), 64'd4);
        chk("t4_vd1",    64'(record_bits_vd[9:5]), 64'd20);
        chk("t4_occ2",   64'(occupancy), 64'd4);
        chk("t4_err",    64'(error), 64'h0);

        // 5: update then update+retire on slot 2
        set_update(3'd2, 7'd3, 32'h000000A5);
        step();
        chk("t5_w3", 64'(mword(2, 3)), 64'hA5);
        set_update(3'd2, 7'd3, 32'h00005A00);
        set_retire(3'd2);
        step();
        chk("t5_valid", 64'(record_valid), 64'hB);
        chk("t5_w3_clr", 64'(mword(2, 3)), 64'h0);
        chk("t5_cmp",   64'(record_complete), 64'h1);
        chk("t5_occ",   64'(occupancy), 64'd3);
        chk("t5_err",   64'(error), 64'h0);

        // 6: orphan update, then asynchronous reset mid-cycle
        set_update(3'd7, 7'd0, 32'h00000001);
        step();
        chk("t6_err",   64'(error), 64'h1);
        chk("t6_s0w0",  64'(mword(0, 0)), 64'hFFFFFFFF);
        chk("t6_s1w0",  64'(mword(1, 0)), 64'h0);
        chk("t6_s3w0",  64'(mword(3, 0)), 64'h0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_ar_valid", 64'(record_valid), 64'h0);
        chk("t6_ar_err",   64'(error), 64'h0);
        chk("t6_ar_occ",   64'(occupancy), 64'h0);
        chk("t6_ar_cmp",   64'(record_complete), 64'h0);
        chk("t6_ar_ready", 64'(issue_ready), 64'h1);

        // Duplicate instIndex is still allocated but flags an error
        @(negedge clock);
        reset = 1'b1;
        set_issue(3'd0, 5'd1);
        step();
        set_issue(3'd0, 5'd2);
        step();
        chk("dup_valid", 64'(record_valid), 64'h3);
        chk("dup_err",   64'(error), 64'h1);
        chk("dup_occ",   64'(occupancy), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
